// File: rtl/sum4_seq_pkg.sv
// Shared constants for the four-operand sequential adder: default width and
// the FSM state encoding.
package sum4_seq_pkg;

   localparam int DEFAULT_BITS = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADD_LEFT  = 3'd1,
      ADD_RIGHT = 3'd2,
      ADD_TOP   = 3'd3,
      DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/add_flow.sv
// Plain combinational modular adder; the carry out is deliberately dropped so
// the sum wraps at 2^width.
module add_flow #(
   parameter int width = 8
) (
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/sum4_sequencer.sv
// (A+B)+(C+D) computed over three cycles on a single shared adder, with
// valid/ready handshakes on the operand and result sides.
module sum4_sequencer
   import sum4_seq_pkg::*;
#(
   parameter int numberOfBits = DEFAULT_BITS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic [numberOfBits-1:0] operandA,
   input  logic [numberOfBits-1:0] operandB,
   input  logic [numberOfBits-1:0] operandC,
   input  logic [numberOfBits-1:0] operandD,
   output logic                    outValid,
   input  logic                    outReady,
   output logic [numberOfBits-1:0] result,
   output logic                    busy
);

   state_t                  state;
   logic [numberOfBits-1:0] opA, opB, opC, opD;
   logic [numberOfBits-1:0] partialLeft, partialRight;
   logic [numberOfBits-1:0] addA, addB, addSum;

   // Both handshake-side indicators are decoded from the registered state and
   // masked by reset so nothing is offered while reset is asserted.
   assign inReady = (state == IDLE) && !reset;
   assign busy    = (state != IDLE) && !reset;

   // IDLE and DONE fall through to the ADD_LEFT sources so the adder never
   // sees undriven inputs.
   always_comb begin
      addA = opA;
      addB = opB;
      case (state)
         ADD_RIGHT: begin
            addA = opC;
            addB = opD;
         end
         ADD_TOP: begin
            addA = partialLeft;
            addB = partialRight;
         end
         default: begin
            addA = opA;
            addB = opB;
         end
      endcase
   end

   add_flow #(
      .width(numberOfBits)
   ) u_add (
      .a  (addA),
      .b  (addB),
      .sum(addSum)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         opA          <= '0;
         opB          <= '0;
         opC          <= '0;
         opD          <= '0;
         partialLeft  <= '0;
         partialRight <= '0;
         result       <= '0;
         outValid     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (inValid && inReady) begin
                  opA   <= operandA;
                  opB   <= operandB;
                  opC   <= operandC;
                  opD   <= operandD;
                  state <= ADD_LEFT;
               end
            end
            ADD_LEFT: begin
               partialLeft <= addSum;
               state       <= ADD_RIGHT;
            end
            ADD_RIGHT: begin
               partialRight <= addSum;
               state        <= ADD_TOP;
            end
            ADD_TOP: begin
               result   <= addSum;
               outValid <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               if (outReady) begin
                  outValid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               // Unused encodings recover to IDLE with no result pending.
               outValid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sum4_sequencer.md
Name: sum4_sequencer

Overview:
Computes the four-operand sum (A+B)+(C+D) by time-sharing one add_flow instance over three cycles, instead of using three adders in a tree.
- Uses valid/ready handshakes on both the operand and result sides.
- Sits in front of any consumer that needs the four-way sum and can tolerate 3-cycle latency in exchange for one third of the adder area.

Parameters:
numberOfBits, 8, width of every operand, partial sum and result

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
inValid  input  1  operand set A..D presented
inReady  output  1  block can accept an operand set this cycle
operandA  input  numberOfBits  first operand of left pair
operandB  input  numberOfBits  second operand of left pair
operandC  input  numberOfBits  first operand of right pair
operandD  input  numberOfBits  second operand of right pair
outValid  output  1  result holds a completed sum
outReady  input  1  consumer accepts result this cycle
result  output  numberOfBits  (A+B)+(C+D) mod 2^numberOfBits
busy  output  1  high whenever state is not IDLE

Behaviour:
- Single clock (clk). Reset is synchronous, active-high.
- Reset values, effective at the edge where reset=1:
  - state=IDLE
  - opA..opD, partialLeft, partialRight, result = 0
  - outValid=0
  - inReady and busy are forced 0 while reset=1.
- States: IDLE, ADD_LEFT, ADD_RIGHT, ADD_TOP, DONE (5 states, 3-bit encoding).
- IDLE:
  - inReady=1.
  - On inValid&inReady, register operandA..D into opA..opD and go to ADD_LEFT.
  - Otherwise stay in IDLE.
- ADD_LEFT: adder inputs = opA, opB; register partialLeft; go to ADD_RIGHT.
- ADD_RIGHT: adder inputs = opC, opD; register partialRight; go to ADD_TOP.
- ADD_TOP: adder inputs = partialLeft, partialRight; register result; go to DONE.
- DONE:
  - outValid=1; result is held stable.
  - On outReady=1, clear outValid and go to IDLE.
  - Otherwise stay in DONE indefinitely.
- inReady is high only in IDLE. inValid in any other state is ignored, and no operand register changes.
- Operand inputs are sampled only at the acceptance edge. Later changes on operandA..D have no effect on the sum in flight.
- Latency: outValid rises 3 clock edges after the acceptance edge.
- Throughput with outReady tied high: one operand set per 5 cycles (accept, 3 adds, DONE handshake, then IDLE accepts again).
- Arithmetic:
  - Every add is numberOfBits wide and truncates to numberOfBits; the carry is discarded.
  - The final value equals (A+B+C+D) mod 2^numberOfBits, bit-identical to a three-adder tree.
- Adder input mux in IDLE and DONE selects the ADD_LEFT sources (opA, opB), so no X reaches the adder.
- Reset mid-operation, in any state:
  - The operation in flight is aborted and the next state is IDLE.
  - outValid=0; no result is delivered for the aborted set.
- Reset in DONE with outReady=1 in the same cycle: reset wins, and the handshake does not count as a delivered transfer.
- No illegal-state lockup: unused encodings go to IDLE.

Decomposition:
- Shared package sum4_seq_pkg holds:
  - the state encoding localparams (IDLE=0, ADD_LEFT=1, ADD_RIGHT=2, ADD_TOP=3, DONE=4)
  - the default width constant 8
- One sub-module: the existing add_flow, instantiated once, with its width parameter overridden to numberOfBits.
- FSM, operand registers, partial-sum registers and the input mux live in sum4_sequencer.

Test Plan:
- Basic sum: after reset, A..D=1,2,3,4 with inValid=1 for one cycle and outReady=1.
  -> inReady drops the next cycle; outValid=1 and result=10 exactly 3 edges after acceptance; back to IDLE one cycle later.
- Wrap-around: A..D=0xFF,0xFF,0x01,0x01.
  -> result=0x00, outValid=1, no extra flag; partialLeft=0xFE and partialRight=0x02 visible internally.
- Backpressure and operand stability: outReady=0 for 6 cycles after outValid; inValid held 1 with new operands; operandA..D toggled during the add states.
  -> result stays 10, outValid stays 1, inReady stays 0, new set not accepted; after outReady=1, IDLE, then the new set is accepted.
- Back-to-back: inValid=1 and outReady=1 held, four sets streamed.
  -> one acceptance every 5 cycles; results in order and all correct.
- Reset mid-operation: assert reset for one cycle while in ADD_TOP.
  -> next cycle state=IDLE, outValid=0, result=0, inReady=1; no outValid pulse for the aborted set.
- Width override, numberOfBits=16: A..D=0x1234,0x1111,0x0001,0x0002.
  -> result=0x2348 after 3 edges.
